// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the seven-segment scan driver.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SLOT_W     = 2;

  typedef logic [6:0] seg_pattern_t;

  localparam seg_pattern_t SEG_BLANK = 7'b0000000;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // One-hot digit enable for a slot index; bit k selects digit k.
  function automatic logic [NUM_DIGITS-1:0] onehot4(input logic [SLOT_W-1:0] sel);
    logic [NUM_DIGITS-1:0] dec;
    case (sel)
      2'd0:    dec = 4'b0001;
      2'd1:    dec = 4'b0010;
      2'd2:    dec = 4'b0100;
      2'd3:    dec = 4'b1000;
      default: dec = 4'b0000;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Digit-slot prescaler: counts 0..DIV_MAX and flags the last cycle of a slot.
// A synchronous clear holds the count at zero (used while not scanning).
module scan_prescaler
  import seg_scan_pkg::*;
#(
  parameter int DIV_MAX = 49999,
  parameter int CNT_W   = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_MAX);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, wrap at the end of the slot, or advance.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/seg_display_scan.sv
// Four-digit seven-segment scan driver. Snapshots the segment patterns and
// drop flag once per frame and multiplexes them onto a shared segment bus
// with one-hot digit enables and blanking guard cycles at each slot start.
// Optional feature: define SEG_BLINK_EN to blink the digits while the
// snapshotted drop flag is set (BLINK_FRAMES frames on, BLINK_FRAMES off).
module seg_display_scan
  import seg_scan_pkg::*;
#(
  parameter int DIV_MAX      = 49999,
  parameter int BLANK_CYC    = 4,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       disp_en,
  input  logic [6:0] seg1,
  input  logic [6:0] seg2,
  input  logic [6:0] seg3,
  input  logic [6:0] seg4,
  input  logic       drop_activated,
  output logic [6:0] seg_out,
  output logic [3:0] dig_sel,
  output logic       frame_start,
  output logic       drop_led
);

  localparam int CNT_W = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  if ((BLANK_CYC > DIV_MAX) || (BLINK_FRAMES < 1)) begin : g_bad_cfg
    $error("seg_display_scan: need BLANK_CYC <= DIV_MAX and BLINK_FRAMES >= 1");
  end

  state_t                        state_q;
  state_t                        state_d;
  logic [SLOT_W-1:0]             slot_q;
  logic [SLOT_W-1:0]             slot_d;
  seg_pattern_t [NUM_DIGITS-1:0] shadow_q;
  seg_pattern_t [NUM_DIGITS-1:0] shadow_d;
  logic                          drop_q;
  logic                          drop_d;

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             scanning;
  logic             frame_wrap;
  logic             load_shadow;
  logic             blink_off;

  // Scanning continues only while in SCAN with the enable held high.
  assign scanning    = (state_q == SCAN) && disp_en;
  assign frame_wrap  = scanning && tick && (slot_q == 2'd3);
  assign load_shadow = ((state_q == IDLE) && disp_en) || frame_wrap;

  scan_prescaler #(
    .DIV_MAX (DIV_MAX),
    .CNT_W   (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!scanning),
    .cnt   (cnt),
    .tick  (tick)
  );

  // State register plus slot index and frame snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      slot_q   <= 2'd0;
      shadow_q <= {NUM_DIGITS{SEG_BLANK}};
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      drop_q   <= drop_d;
    end
  end

  // Next state: the enable alone decides between idling and scanning.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (disp_en) state_d = SCAN;
        else         state_d = IDLE;
      end
      SCAN: begin
        if (disp_en) state_d = SCAN;
        else         state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Slot advance on each prescaler tick; snapshot reload at scan entry and frame wrap.
  always_comb begin
    slot_d   = slot_q;
    shadow_d = shadow_q;
    drop_d   = drop_q;
    if (!scanning) begin
      slot_d = 2'd0;
    end else if (tick) begin
      slot_d = slot_q + 2'd1;
    end else begin
      slot_d = slot_q;
    end
    if (load_shadow) begin
      shadow_d = {seg4, seg3, seg2, seg1};
      drop_d   = drop_activated;
    end else begin
      shadow_d = shadow_q;
      drop_d   = drop_q;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [BLINK_W-1:0] BLINK_ZERO = {BLINK_W{1'b0}};
  localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);

  logic [BLINK_W-1:0] blink_cnt_q;
  logic [BLINK_W-1:0] blink_cnt_d;
  logic               phase_q;
  logic               phase_d;

  // Frame counter toggles the blink phase every BLINK_FRAMES frames; idle restarts it visible.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (state_q == IDLE) begin
      blink_cnt_d = BLINK_ZERO;
      phase_d     = 1'b0;
    end else if (frame_wrap) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = BLINK_ZERO;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_ONE;
        phase_d     = phase_q;
      end
    end else begin
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= BLINK_ZERO;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blink_off = drop_q && phase_q;
`else
  assign blink_off = 1'b0;
`endif

  // Output decode from registers only: bus shows the slot pattern, enables gated by guard and blink.
  always_comb begin
    seg_out     = SEG_BLANK;
    dig_sel     = 4'b0000;
    frame_start = 1'b0;
    drop_led    = 1'b0;
    case (state_q)
      SCAN: begin
        seg_out = shadow_q[slot_q];
        if ((cnt >= BLANK_END) && !blink_off) begin
          dig_sel = onehot4(slot_q);
        end else begin
          dig_sel = 4'b0000;
        end
        frame_start = (slot_q == 2'd0) && (cnt == CNT_ZERO);
        drop_led    = drop_q;
      end
      default: begin
        seg_out     = SEG_BLANK;
        dig_sel     = 4'b0000;
        frame_start = 1'b0;
        drop_led    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// Self-checking bench for seg_display_scan (DIV_MAX=7, BLANK_CYC=2, BLINK_FRAMES=2).
// Honors SEG_BLINK_EN to match the build of the design.
module tb_seg_display_scan;

  localparam int DIV_MAX      = 7;
  localparam int BLANK_CYC    = 2;
  localparam int BLINK_FRAMES = 2;
  localparam int SLOT_LEN     = DIV_MAX + 1;
  localparam int FRAME_LEN    = 4 * SLOT_LEN;

  logic       clk            = 1'b0;
  logic       rst_n          = 1'b1;
  logic       disp_en        = 1'b0;
  logic       drop_activated = 1'b0;
  logic [6:0] seg1           = 7'b0000000;
  logic [6:0] seg2           = 7'b0000000;
  logic [6:0] seg3           = 7'b0000000;
  logic [6:0] seg4           = 7'b0000000;
  logic [6:0] seg_out;
  logic [3:0] dig_sel;
  logic       frame_start;
  logic       drop_led;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seg_display_scan #(
    .DIV_MAX      (DIV_MAX),
    .BLANK_CYC    (BLANK_CYC),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .disp_en        (disp_en),
    .seg1           (seg1),
    .seg2           (seg2),
    .seg3           (seg3),
    .seg4           (seg4),
    .drop_activated (drop_activated),
    .seg_out        (seg_out),
    .dig_sel        (dig_sel),
    .frame_start    (frame_start),
    .drop_led       (drop_led)
  );

  // Reference model: cycles elapsed since the scan started plus the latest frame snapshot.
  bit         m_on   = 1'b0;
  int         m_t    = 0;
  logic [6:0] m_seg [4] = '{default: 7'b0000000};
  logic       m_drop = 1'b0;

  // Model update on each clock edge and on asynchronous reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_on = 1'b0;
      m_t  = 0;
      for (int i = 0; i < 4; i++) m_seg[i] = 7'b0000000;
      m_drop = 1'b0;
    end else if (!disp_en) begin
      m_on = 1'b0;
      m_t  = 0;
    end else begin
      if (!m_on) begin
        m_on = 1'b1;
        m_t  = 0;
      end else begin
        m_t = m_t + 1;
      end
      if (m_t % FRAME_LEN == 0) begin
        m_seg[0] = seg1;
        m_seg[1] = seg2;
        m_seg[2] = seg3;
        m_seg[3] = seg4;
        m_drop   = drop_activated;
      end
    end
  end

  // Expected outputs from the position inside the frame.
  task automatic model_expect(output logic [6:0] e_seg, output logic [3:0] e_dig,
                              output logic e_fs, output logic e_led);
    int p;
    int slot;
    int off;
    e_seg = 7'b0000000;
    e_dig = 4'b0000;
    e_fs  = 1'b0;
    e_led = 1'b0;
    if (rst_n && m_on) begin
      p     = m_t % FRAME_LEN;
      slot  = p / SLOT_LEN;
      off   = p % SLOT_LEN;
      e_seg = m_seg[slot];
      e_led = m_drop;
      e_fs  = (p == 0);
      if (off >= BLANK_CYC) e_dig = 4'(1 << slot);
`ifdef SEG_BLINK_EN
      if (m_drop && (((m_t / FRAME_LEN) / BLINK_FRAMES) % 2 == 1)) e_dig = 4'b0000;
`endif
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    logic [6:0] e_seg;
    logic [3:0] e_dig;
    logic       e_fs;
    logic       e_led;
    model_expect(e_seg, e_dig, e_fs, e_led);
    vectors++;
    if ({seg_out, dig_sel, frame_start, drop_led} !== {e_seg, e_dig, e_fs, e_led}) begin
      miscompares++;
      $display("FAIL cycle_model t=%0t: got seg=%b dig=%b fs=%b led=%b, want seg=%b dig=%b fs=%b led=%b",
               $time, seg_out, dig_sel, frame_start, drop_led, e_seg, e_dig, e_fs, e_led);
    end
  end

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s t=%0t: got %b, want %b", name, $time, got, want);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_seg"}, seg_out, 7'b0000000);
    check({name, "_dig"}, {3'b000, dig_sel}, 7'b0000000);
    check({name, "_fs"},  {6'b000000, frame_start}, 7'b0000000);
    check({name, "_led"}, {6'b000000, drop_led}, 7'b0000000);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick(3);
    check_all_zero("in_reset");
    rst_n = 1'b1;
    tick(20);
    check_all_zero("idle_after_reset");

    // Basic scan with "cold".
    seg1 = 7'b0111001; seg2 = 7'b1011100; seg3 = 7'b0111000; seg4 = 7'b1011110;
    disp_en = 1'b1;
    tick(1);
    check("first_fs",  {6'b000000, frame_start}, 7'b0000001);
    check("first_seg", seg_out, 7'b0111001);
    check("first_dig", {3'b000, dig_sel}, 7'b0000000);
    tick(1);
    check("guard2_dig", {3'b000, dig_sel}, 7'b0000000);
    tick(1);
    check("lit0_dig", {3'b000, dig_sel}, 7'b0000001);
    tick(5);
    check("lit0_end_dig", {3'b000, dig_sel}, 7'b0000001);
    tick(1);
    check("slot1_seg", seg_out, 7'b1011100);
    check("slot1_guard", {3'b000, dig_sel}, 7'b0000000);
    check("slot1_fs", {6'b000000, frame_start}, 7'b0000000);
    tick(2);
    check("slot1_dig", {3'b000, dig_sel}, 7'b0000010);

    // Mid-frame change to "drop": current frame keeps "cold".
    seg1 = 7'b1011110; seg2 = 7'b1010000; seg3 = 7'b1011100; seg4 = 7'b1110011;
    tick(6);
    check("slot2_old_seg", seg_out, 7'b0111000);
    tick(8);
    check("slot3_old_seg", seg_out, 7'b1011110);
    tick(8);
    check("frame1_fs",  {6'b000000, frame_start}, 7'b0000001);
    check("frame1_seg", seg_out, 7'b1011110);
    tick(8);
    check("frame1_slot1_seg", seg_out, 7'b1010000);

    // Disable in slot 2 at cnt 4, then re-enable.
    tick(12);
    check("slot2_cnt4_dig", {3'b000, dig_sel}, 7'b0000100);
    check("slot2_cnt4_seg", seg_out, 7'b1011100);
    disp_en = 1'b0;
    tick(1);
    check_all_zero("disabled");
    tick(3);
    disp_en = 1'b1;
    tick(1);
    check("restart_fs",  {6'b000000, frame_start}, 7'b0000001);
    check("restart_seg", seg_out, 7'b1011110);
    check("restart_dig", {3'b000, dig_sel}, 7'b0000000);
    tick(1);
    check("restart_guard_dig", {3'b000, dig_sel}, 7'b0000000);
    tick(1);
    check("restart_lit_dig", {3'b000, dig_sel}, 7'b0000001);

    // Asynchronous reset between edges while digit 2 is lit.
    tick(16);
    check("pre_areset_dig", {3'b000, dig_sel}, 7'b0000100);
    #2;
    rst_n   = 1'b0;
    disp_en = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick(2);
    rst_n = 1'b1;
    tick(4);
    check_all_zero("idle_after_areset");

    // Reset released with disp_en high and drop flag set: blink run.
    rst_n          = 1'b0;
    disp_en        = 1'b1;
    drop_activated = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("blink_entry_fs",  {6'b000000, frame_start}, 7'b0000001);
    check("blink_entry_seg", seg_out, 7'b1011110);
    check("blink_entry_led", {6'b000000, drop_led}, 7'b0000001);
    tick(66);
`ifdef SEG_BLINK_EN
    check("frame2_dig", {3'b000, dig_sel}, 7'b0000000);
`else
    check("frame2_dig", {3'b000, dig_sel}, 7'b0000001);
`endif
    check("frame2_led", {6'b000000, drop_led}, 7'b0000001);
    tick(64);
    check("frame4_dig", {3'b000, dig_sel}, 7'b0000001);
    tick(64);
`ifdef SEG_BLINK_EN
    check("frame6_dig", {3'b000, dig_sel}, 7'b0000000);
`else
    check("frame6_dig", {3'b000, dig_sel}, 7'b0000001);
`endif
    check("frame6_led", {6'b000000, drop_led}, 7'b0000001);
    tick(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_display_scan.md
# seg_display_scan

Time-multiplexed driver for the four-digit seven-segment display that sits directly downstream of the baggage-drop decision logic. It takes the four static 7-bit segment patterns and the drop flag, snapshots them once per refresh frame, and scans them onto a single shared segment bus with one-hot digit enables. Blanking guard cycles between digits prevent ghosting.

## Interface
- DIV_MAX, 49999: clocks per digit slot minus 1 (1 ms/digit at 50 MHz).
- BLANK_CYC, 4: guard cycles at slot start with all digits off; must satisfy BLANK_CYC <= DIV_MAX (elaboration error otherwise).
- BLINK_FRAMES, 125: frames per blink half-period (used only with SEG_BLINK_EN).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- disp_en  in  1  display enable; low forces blank/idle.
- seg1, seg2, seg3, seg4  in  7 each  segment patterns for digits 0..3 (active-high segments).
- drop_activated  in  1  drop flag from the decision stage.
- seg_out  out  7  shared segment bus.
- dig_sel  out  4  one-hot digit enable, active-high; bit k selects seg(k+1).
- frame_start  out  1  one-cycle pulse on the first cycle of every frame.
- drop_led  out  1  snapshotted drop flag.

## Operation
- Registers: state (IDLE/SCAN), cnt (0..DIV_MAX), slot (0..3), shadow (4x7 segments + drop bit), blink counter/phase (config only).
- Reset: state=IDLE, cnt=0, slot=0, shadow=0. All outputs 0.
- Outputs are decoded from registers only; there is no combinational path from input to output.
- IDLE: seg_out=0, dig_sel=0, frame_start=0, drop_led=0. The shadow register retains its contents.
- IDLE->SCAN: on the edge where disp_en=1. At that edge, cnt=0 and slot=0, and shadow loads seg1..4 and drop_activated.
- SCAN->IDLE: on any edge where disp_en=0. cnt and slot clear, and outputs are 0 from the next cycle.
- SCAN, per edge:
  - If cnt<DIV_MAX, cnt increments.
  - Otherwise cnt returns to 0 and slot increments.
  - When slot==3 and cnt==DIV_MAX, slot wraps to 0 and shadow reloads from the inputs on that same edge.
- SCAN outputs:
  - seg_out = shadow[slot].
  - dig_sel = onehot(slot) when cnt>=BLANK_CYC, else 4'b0000.
  - frame_start = (slot==0 && cnt==0).
  - drop_led = shadow drop bit.
- Input changes within a frame are invisible until the next frame_start. This gives tear-free display.
- seg_out is valid during the blanking cycles; only dig_sel is gated.

## Timing
- Slot length = DIV_MAX+1 clocks; digit lit for DIV_MAX+1-BLANK_CYC clocks.
- Frame length = 4*(DIV_MAX+1) clocks. frame_start period is exactly that while disp_en stays high.
- Latency: disp_en rising to frame_start = 1 cycle; disp_en falling to blank = 1 cycle.
- Input-to-display latency: at most one frame plus 1 cycle.
- Async reset mid-scan: outputs go to 0 immediately, with no clock required. After release, the block waits in IDLE for disp_en.
- disp_en high during reset release: SCAN is entered on the first edge after release.

## Configuration
- SEG_BLINK_EN defined:
  - A frame counter 0..BLINK_FRAMES-1 toggles phase at each wrap.
  - Phase resets to 0 (visible) on entry to SCAN.
  - When the shadow drop bit is 1 and phase=1, dig_sel is forced to 0.
  - drop_led is unaffected by blinking.
- SEG_BLINK_EN undefined: no blink logic; BLINK_FRAMES is ignored and dig_sel is never phase-gated.

## Structure
- Package seg_scan_pkg holds:
  - NUM_DIGITS=4 and SLOT_W=2.
  - A seg_pattern_t 7-bit typedef.
  - SEG_BLANK=7'b0000000.
  - The state enum {IDLE, SCAN}.
  - A onehot4 decode function.
- One sub-module, scan_prescaler, owns cnt and the slot tick (DIV_MAX, clear input, tick output). The top level holds the FSM, shadow register and output decode.

## Test plan
All scenarios use bench parameters DIV_MAX=7, BLANK_CYC=2, BLINK_FRAMES=2.
- **Reset:** hold rst_n=0, then release with disp_en=0 for 20 cycles -> all outputs 0 throughout.
- **Basic scan:** raise disp_en with seg1..4 = 0111001, 1011100, 0111000, 1011110 ("cold"). Required response:
  - Next cycle: frame_start=1 and seg_out=0111001.
  - dig_sel=0000 for 2 cycles, then 0001 for 6 cycles.
  - Then seg_out=1011100 with dig_sel gated, then 0010, and so on.
  - frame_start repeats every 32 cycles.
- **Mid-frame change:** change inputs to "drop" (1011110, 1010000, 1011100, 1110011) during slot 1 -> slots 1..3 still show the "cold" patterns. Slot 0 of the next frame shows 1011110, coincident with frame_start.
- **Disable mid-slot:** drop disp_en during slot 2, cnt=4 -> next cycle all outputs 0. Re-raise disp_en -> restart at slot 0 with a frame_start pulse, dig_sel gated for 2 cycles.
- **Async reset:** assert rst_n between clock edges while dig_sel=0100 -> all outputs 0 before the next edge.
- **Blink:** drop_activated=1, disp_en=1.
  - With SEG_BLINK_EN: digits light normally in frames 0-1, dig_sel=0 for all of frames 2-3, and the pattern repeats. drop_led stays 1 throughout.
  - Without SEG_BLINK_EN: every frame lights normally.
